// File: rtl/rk_stage_sequencer.sv
// -----------------------------------------------------------------------------
// rk_stage_sequencer
// Control sequencer for the iterative differentiator datapath. It steers
// operand loads, steps through NUM_STAGES compute stages per iteration and
// keeps looping while continue_while is high, up to a runtime iteration cap.
//
// Optional feature macro: CTRL_TIMEOUT_EN
//   When defined, a per-stage watchdog moves the FSM to ERROR if a stage does
//   not finish within TIMEOUT_CYC cycles. When undefined, COMPUTE waits
//   indefinitely and error is tied low.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   start          begin a run from IDLE, DONE or ERROR
//   op_sel         operand load requests, lowest set bit wins
//   ready          all operands present, leave READ
//   compute_done   current stage finished (single-cycle pulse)
//   continue_while loop condition, sampled in CHECK
//   max_iter       iteration cap, 0 = unlimited
//   load_en        registered one-hot operand load strobe
//   stage          current compute stage index
//   state          encoded FSM state (IDLE=0 .. ERROR=5)
//   iter_cnt       completed iterations, saturating
//   busy           high in COMPUTE or CHECK
//   valid          high in DONE
//   error          high in ERROR
// -----------------------------------------------------------------------------
module rk_stage_sequencer #(
  parameter int NUM_OPS     = 4,
  parameter int NUM_STAGES  = 4,
  parameter int ITER_W      = 16,
  parameter int TIMEOUT_CYC = 1024,
  localparam int STG_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [NUM_OPS-1:0] op_sel,
  input  logic               ready,
  input  logic               compute_done,
  input  logic               continue_while,
  input  logic [ITER_W-1:0]  max_iter,
  output logic [NUM_OPS-1:0] load_en,
  output logic [STG_W-1:0]   stage,
  output logic [2:0]         state,
  output logic [ITER_W-1:0]  iter_cnt,
  output logic               busy,
  output logic               valid,
  output logic               error
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_COMPUTE = 3'd2,
    S_CHECK   = 3'd3,
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  localparam logic [STG_W-1:0] STG_LAST = STG_W'(NUM_STAGES - 1);

  // Parameter sanity: reject degenerate configurations at elaboration.
  if (NUM_OPS < 1 || NUM_STAGES < 1 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("rk_stage_sequencer: NUM_OPS, NUM_STAGES and TIMEOUT_CYC must be >= 1");
  end

  // Isolates the lowest set request bit: x & -x.
  function automatic logic [NUM_OPS-1:0] lowest_onehot(input logic [NUM_OPS-1:0] req);
    lowest_onehot = req & (~req + NUM_OPS'(1));
  endfunction

  state_t               state_q, state_d;
  logic [NUM_OPS-1:0]   load_en_q, load_en_d;
  logic [STG_W-1:0]     stage_q, stage_d;
  logic [ITER_W-1:0]    iter_q, iter_d;

`ifdef CTRL_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] wdog_q, wdog_d;

  // Per-stage watchdog register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`endif

  // Control state, strobe, stage and iteration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      load_en_q <= '0;
      stage_q   <= '0;
      iter_q    <= '0;
    end else begin
      state_q   <= state_d;
      load_en_q <= load_en_d;
      stage_q   <= stage_d;
      iter_q    <= iter_d;
    end
  end

  // Next-state and datapath-control decode.
  always_comb begin
    state_d   = state_q;
    load_en_d = '0;
    stage_d   = stage_q;
    iter_d    = iter_q;
`ifdef CTRL_TIMEOUT_EN
    // Counter is only meaningful in COMPUTE; everywhere else it sits at 0,
    // which also gives the clear-on-entry behaviour.
    wdog_d    = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_READ;
        else       state_d = S_IDLE;
      end
      S_READ: begin
        // The request on the ready edge is still loaded.
        load_en_d = lowest_onehot(op_sel);
        if (ready) begin
          state_d = S_COMPUTE;
          stage_d = '0;
          iter_d  = '0;
        end else begin
          state_d = S_READ;
        end
      end
      S_COMPUTE: begin
        if (compute_done) begin
          if (stage_q == STG_LAST) begin
            state_d = S_CHECK;
            if (iter_q == {ITER_W{1'b1}}) iter_d = iter_q;
            else                          iter_d = iter_q + ITER_W'(1);
          end else begin
            stage_d = stage_q + STG_W'(1);
          end
        end else begin
`ifdef CTRL_TIMEOUT_EN
          if (wdog_q == TO_LAST) state_d = S_ERROR;
          else                   wdog_d  = wdog_q + TO_W'(1);
`else
          state_d = S_COMPUTE;
`endif
        end
      end
      S_CHECK: begin
        // iter_cnt already includes the iteration that just finished.
        if (continue_while && (max_iter == '0 || iter_q < max_iter)) begin
          state_d = S_COMPUTE;
          stage_d = '0;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start) state_d = S_READ;
        else       state_d = S_DONE;
      end
`ifdef CTRL_TIMEOUT_EN
      S_ERROR: begin
        if (start) state_d = S_READ;
        else       state_d = S_ERROR;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign load_en  = load_en_q;
  assign stage    = stage_q;
  assign state    = state_q;
  assign iter_cnt = iter_q;
  assign busy     = (state_q == S_COMPUTE) || (state_q == S_CHECK);
  assign valid    = (state_q == S_DONE);
`ifdef CTRL_TIMEOUT_EN
  assign error    = (state_q == S_ERROR);
`else
  assign error    = 1'b0;
`endif

endmodule
